poly_dataout: RTL and testbench

POLY_DATAOUT -- requirements
Module: poly_dataout

---
 rtl/poly_dataout_pkg.sv | 19 +
 rtl/poly_csub.sv | 22 ++
 rtl/poly_dataout.sv | 162 ++++++++++++++++
 tb/tb_poly_dataout.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_dataout_pkg.sv
// Shared constants and state encoding for the polynomial unload path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package poly_dataout_pkg;

  localparam int KYBER_Q = 3329;
  localparam int WID     = 12;        // coefficient width
  localparam int DWID    = WID * 4;   // RAM word: four coefficients
  localparam int ADDWID  = 5;         // 32 words per polynomial
  localparam int NCOEF   = 128;       // coefficients per unload

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/poly_csub.sv
// Conditional subtraction of q from one coefficient (value >= q -> value - q).
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//
// Ports:
//   din  - coefficient in
//   en   - enable the subtraction; when low din passes through
//   dout - coefficient out
module poly_csub #(
  parameter int WID = poly_dataout_pkg::WID
) (
  input  logic [WID-1:0] din,
  input  logic           en,
  output logic [WID-1:0] dout
);
  import poly_dataout_pkg::*;

  localparam logic [WID-1:0] Q = WID'(KYBER_Q);

  assign dout = (en && (din >= Q)) ? (din - Q) : din;

endmodule

// File: rtl/poly_dataout.sv
// Unloads a 128-coefficient polynomial from a 4-coefficient-per-word RAM as a valid/ready stream.
// Latency: first coef_valid 3 cycles after start is sampled; then one coefficient per cycle with ready high.
// Backpressure: coef_ready low stalls the stream; reads stop once buffered + in-flight words reach 2.
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   start, csub       - begin unload (IDLE only); csub latched at start
//   ram_ra, ram_rdo   - RAM read address / data (data one cycle after address is presented)
//   coef_out/_valid/_ready/_last - output coefficient stream, last marks coefficient 127
//   busy, done        - busy from the cycle after start until done; done is a one-cycle pulse
module poly_dataout #(
  parameter int WID    = poly_dataout_pkg::WID,
  parameter int DWID   = poly_dataout_pkg::DWID,
  parameter int ADDWID = poly_dataout_pkg::ADDWID
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              csub,
  output logic [ADDWID-1:0] ram_ra,
  input  logic [DWID-1:0]   ram_rdo,
  output logic [WID-1:0]    coef_out,
  output logic              coef_valid,
  input  logic              coef_ready,
  output logic              coef_last,
  output logic              busy,
  output logic              done
);
  import poly_dataout_pkg::*;

  // Address issued just before FETCH may leave: the next issue is the final word.
  localparam logic [ADDWID-1:0] ADDR_PENULT = ADDWID'((2 ** ADDWID) - 2);
  localparam logic [6:0]        CNT_LAST    = 7'(NCOEF - 1);

  state_t            state;
  logic              csub_r;

  // Read pipeline: rd_v = address presented this cycle, ret_v = data on ram_rdo this cycle.
  logic              rd_v;
  logic              ret_v;

  // Two-entry word buffer.
  logic [DWID-1:0]   buf_dat [2];
  logic              wr_ptr;
  logic              rd_ptr;
  logic [1:0]        buf_cnt;
  logic [1:0]        lane;
  logic [6:0]        coef_cnt;

  logic              issue;
  logic              xfer;
  logic              free_ent;
  logic [2:0]        occ;
  logic [DWID-1:0]   head;
  logic [WID-1:0]    lane_val;

  assign coef_valid = (buf_cnt != 2'd0);
  assign xfer       = coef_valid & coef_ready;
  assign free_ent   = xfer && (lane == 2'd3);
  assign coef_last  = coef_valid && (coef_cnt == CNT_LAST);

  // Reads in flight count against the buffer so a returning word always has a slot.
  assign occ   = {1'b0, buf_cnt} + {2'b00, rd_v} + {2'b00, ret_v};
  // Word 0 is requested on the start cycle itself to meet the 3-cycle first-valid bound.
  assign issue = ((state == IDLE) && start) || ((state == FETCH) && (occ < 3'd2));

  always_comb begin
    head     = buf_dat[rd_ptr];
    lane_val = head[WID-1:0];
    case (lane)
      2'd0:    lane_val = head[0*WID +: WID];
      2'd1:    lane_val = head[1*WID +: WID];
      2'd2:    lane_val = head[2*WID +: WID];
      default: lane_val = head[3*WID +: WID];
    endcase
  end

  poly_csub #(.WID(WID)) u_csub (
    .din  (lane_val),
    .en   (csub_r),
    .dout (coef_out)
  );

  // Control FSM and read issue.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ram_ra <= '0;
      rd_v   <= 1'b0;
      ret_v  <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      csub_r <= 1'b0;
    end else begin
      rd_v  <= issue;
      ret_v <= rd_v;
      done  <= 1'b0;
      if (issue) begin
        ram_ra <= (state == IDLE) ? '0 : (ram_ra + ADDWID'(1));
      end
      case (state)
        IDLE: begin
          if (start) begin
            state  <= FETCH;
            busy   <= 1'b1;
            csub_r <= csub;
          end
        end
        FETCH: begin
          if (issue && (ram_ra == ADDR_PENULT)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (xfer && (coef_cnt == CNT_LAST)) begin
            state <= FIN;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Buffer bookkeeping; push and free in the same cycle leave the count unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      buf_cnt  <= 2'd0;
      lane     <= 2'd0;
      coef_cnt <= 7'd0;
    end else begin
      if (ret_v) begin
        wr_ptr <= ~wr_ptr;
      end
      if (free_ent) begin
        rd_ptr <= ~rd_ptr;
      end
      if (xfer) begin
        lane     <= lane + 2'd1;
        coef_cnt <= coef_cnt + 7'd1;
      end
      case ({ret_v, free_ent})
        2'b10:   buf_cnt <= buf_cnt + 2'd1;
        2'b01:   buf_cnt <= buf_cnt - 2'd1;
        default: buf_cnt <= buf_cnt;
      endcase
    end
  end

  // Word storage needs no reset: buf_cnt gates visibility.
  always_ff @(posedge clk) begin
    if (ret_v) begin
      buf_dat[wr_ptr] <= ram_rdo;
    end
  end

endmodule

// File: tb/tb_poly_dataout.sv
module tb_poly_dataout;
  localparam int WID    = 12;
  localparam int DWID   = 48;
  localparam int ADDWID = 5;
  localparam int Q      = 3329;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              csub;
  logic [ADDWID-1:0] ram_ra;
  logic [DWID-1:0]   ram_rdo;
  logic [WID-1:0]    coef_out;
  logic              coef_valid;
  logic              coef_ready;
  logic              coef_last;
  logic              busy;
  logic              done;

  poly_dataout #(.WID(WID), .DWID(DWID), .ADDWID(ADDWID)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .csub       (csub),
    .ram_ra     (ram_ra),
    .ram_rdo    (ram_rdo),
    .coef_out   (coef_out),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef_last  (coef_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  // Synchronous-read RAM model.
  logic [DWID-1:0] mem [32];
  always @(posedge clk) ram_rdo <= mem[ram_ra];

  typedef struct {
    logic [WID-1:0] v;
    logic           last;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   rdy_mode = 0;   // 0: always ready, 1: random 50%, 2: held low
  int   xfer_cnt = 0;
  int   done_cnt = 0;
  int   cyc = 0;
  int   first_x = -1;
  int   last_x = -1;
  logic pend_done = 1'b0;
  logic prev_stall = 1'b0;
  logic [WID-1:0] prev_out = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0:       coef_ready = 1'b1;
      1:       coef_ready = 1'($urandom_range(0, 1));
      default: coef_ready = 1'b0;
    endcase
  end

  // Monitor: pops the scoreboard on every transfer.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pend_done  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (done || pend_done) chk("done_pulse", 64'(done), 64'(pend_done));
      if (done) done_cnt++;
      pend_done = 1'b0;
      if (prev_stall) begin
        chk("hold_valid", 64'(coef_valid), 64'd1);
        chk("hold_data", 64'(coef_out), 64'(prev_out));
      end
      if (coef_valid && coef_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_xfer: got coef %0d, expected no transfer", coef_out);
        end else begin
          e = exp_q.pop_front();
          chk("coef_out", 64'(coef_out), 64'(e.v));
          chk("coef_last", 64'(coef_last), 64'(e.last));
          if (e.last) pend_done = 1'b1;
        end
        xfer_cnt++;
        if (first_x < 0) first_x = cyc;
        last_x = cyc;
      end
      prev_stall = coef_valid && !coef_ready;
      prev_out   = coef_out;
    end
  end

  // Reference: coefficient i is lane i%4 of word i/4, optionally reduced by q.
  task automatic push_exp(input bit cs);
    for (int i = 0; i < 128; i++) begin
      logic [DWID-1:0] w;
      int   v;
      exp_t e;
      w = mem[i / 4];
      v = int'((w >> (WID * (i % 4))) & 48'hFFF);
      if (cs && v >= Q) v = v - Q;
      e.v    = v[WID-1:0];
      e.last = (i == 127);
      exp_q.push_back(e);
    end
  endtask

  task automatic fill_inc();
    for (int k = 0; k < 32; k++)
      mem[k] = {WID'(4*k+3), WID'(4*k+2), WID'(4*k+1), WID'(4*k)};
  endtask

  task automatic fill_rand();
    for (int k = 0; k < 32; k++)
      mem[k] = {16'($urandom), 32'($urandom)};
  endtask

  task automatic fill_csub();
    for (int k = 0; k < 32; k++)
      mem[k] = {12'd0, 12'd4095, 12'd3329, 12'd3328};
  endtask

  task automatic do_start(input bit cs);
    @(posedge clk); #1;
    start = 1'b1;
    csub  = cs;
    @(posedge clk); #1;
    start = 1'b0;
    csub  = ~cs;   // must be ignored: latched at start
  endtask

  task automatic wait_xfers(input int n);
    int t;
    t = 0;
    while (xfer_cnt < n && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    chk("xfer_wait_timeout", 64'(xfer_cnt >= n), 64'd1);
  endtask

  task automatic run_full(input bit cs, input int mode, input int stall, input int restart_at);
    int lat;
    int d0;
    int t;
    int max_ra;
    exp_q.delete();
    push_exp(cs);
    xfer_cnt = 0;
    first_x  = -1;
    d0       = done_cnt;
    rdy_mode = (stall > 0) ? 2 : mode;
    do_start(cs);
    chk("busy_after_start", 64'(busy), 64'd1);
    lat = 0;
    while (!coef_valid && lat < 10) begin
      @(negedge clk); #1;
      lat++;
    end
    chk("first_valid_latency_le3", 64'(lat <= 3), 64'd1);
    if (stall > 0) begin
      max_ra = 0;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk); #1;
        if (int'(ram_ra) > max_ra) max_ra = int'(ram_ra);
      end
      chk("stall_max_ra", 64'(max_ra), 64'd1);
      chk("stall_ram_ra", 64'(ram_ra), 64'd1);
      chk("stall_no_xfer", 64'(xfer_cnt), 64'd0);
      rdy_mode = mode;
    end
    if (restart_at > 0) begin
      wait_xfers(restart_at);
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    t = 0;
    while (done_cnt == d0 && t < 3000) begin
      @(negedge clk); #1;
      t++;
    end
    repeat (4) @(negedge clk);
    #1;
    chk("done_count", 64'(done_cnt - d0), 64'd1);
    chk("xfer_count", 64'(xfer_cnt), 64'd128);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    if (mode == 0 && stall == 0) chk("no_bubbles", 64'(last_x - first_x), 64'd127);
  endtask

  initial begin
    int d0;
    rst        = 1'b1;
    start      = 1'b0;
    csub       = 1'b0;
    coef_ready = 1'b1;
    fill_inc();
    repeat (3) @(posedge clk);
    #1;
    start = 1'b1;          // reset must win over start
    @(posedge clk); #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk); #1;
    chk("rst_ram_ra", 64'(ram_ra), 64'd0);
    chk("rst_valid", 64'(coef_valid), 64'd0);
    chk("rst_last", 64'(coef_last), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);

    // Counting RAM, ready high.
    run_full(1'b0, 0, 0, 0);
    // Counting RAM, random ready.
    run_full(1'b0, 1, 0, 0);
    // Boundary values around q, with and without reduction.
    fill_csub();
    run_full(1'b1, 0, 0, 0);
    run_full(1'b0, 1, 0, 0);
    // Random data with reduction and random ready.
    fill_rand();
    run_full(1'b1, 1, 0, 0);
    // Long stall right after start.
    fill_inc();
    run_full(1'b0, 0, 20, 0);
    // Start pulsed mid-unload is ignored.
    run_full(1'b0, 1, 0, 40);

    // Abort after 50 transfers.
    exp_q.delete();
    push_exp(1'b0);
    xfer_cnt = 0;
    rdy_mode = 0;
    do_start(1'b0);
    wait_xfers(50);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = done_cnt;
    @(negedge clk); #1;
    chk("abort_valid", 64'(coef_valid), 64'd0);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_ram_ra", 64'(ram_ra), 64'd0);
    repeat (10) @(negedge clk);
    #1;
    chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
    chk("abort_still_idle", 64'(coef_valid), 64'd0);
    run_full(1'b0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
